rotate_arbiter: RTL

Shares one 32-bit rotate datapath between NUM_REQ independent requesters. Requesters use valid/ready handshakes.
- Round-robin arbitration picks one requester and latches its operand, shift amount and direction.
- The rotation is computed in a registered stage.
- The result is returned on a single response channel, tagged with the requester ID.
- Sits between client blocks (counters, hash/scramble units) and the shared rotator; replaces per-client rotators.

---
 rtl/rotate_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit rotator among NUM_REQ requesters.
// Latency: accept -> rsp_valid in 2 cycles; one op per 3 cycles at best.
// Backpressure: a pending response stalls everything; req_ready stays low until rsp_ready.
module rotate_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int SHW     = 5,
    parameter int IDW     = 2,
    parameter int CNTW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SHW-1:0]   req_shift,
    input  logic [NUM_REQ-1:0]       req_left,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy,
    output logic [CNTW-1:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [IDW-1:0]   cidx;
    logic             accept;
    logic             rsp_done;

    logic [WIDTH-1:0] lat_data;
    logic [SHW-1:0]   lat_shift;
    logic             lat_left;
    logic [IDW-1:0]   lat_id;

    logic [SHW:0]     inv_shift;
    logic [WIDTH-1:0] rot_result;

    // Search upward from the slot after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cidx        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cidx = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (!grant_found && req_valid[cidx]) begin
                grant_found = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                    // Gated so req_ready reads 0 while reset is held, even with requests pending.
                    req_ready[grant_idx] = rst_n;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // WIDTH-s is kept at SHW+1 bits so s=0 makes the wrap term shift out completely.
    always_comb begin
        inv_shift = (SHW+1)'(WIDTH) - {1'b0, lat_shift};
        if (lat_left) begin
            rot_result = (lat_data << lat_shift) | (lat_data >> inv_shift);
        end else begin
            rot_result = (lat_data >> lat_shift) | (lat_data << inv_shift);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NUM_REQ - 1);
            lat_data   <= '0;
            lat_shift  <= '0;
            lat_left   <= 1'b0;
            lat_id     <= '0;
        end else if (accept) begin
            last_grant <= grant_idx;
            lat_data   <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
            lat_shift  <= req_shift[int'(grant_idx)*SHW +: SHW];
            lat_left   <= req_left[grant_idx];
            lat_id     <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_data <= rot_result;
                rsp_id   <= lat_id;
            end
            if (rsp_done) begin
                op_count <= op_count + CNTW'(1);
            end
        end
    end

endmodule
